// File: rtl/inst_fetch_bridge_pkg.sv
// Shared types for the instruction fetch bridge: FSM states, NOP word, line-buffer entry.
// Entry widths follow the core's InstAddrBus (32) / InstBus (32) widths.
package inst_fetch_bridge_pkg;

    localparam int INST_ADDR_BUS_W = 32;
    localparam int INST_BUS_W      = 32;
    localparam int LINE_TAG_W      = INST_ADDR_BUS_W - 2;

    localparam logic [31:0] NOP = 32'h0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_CANCEL
    } fetch_state_e;

    typedef struct packed {
        logic                  valid;
        logic [LINE_TAG_W-1:0] tag;
        logic [INST_BUS_W-1:0] data;
    } line_entry_t;

endpackage

// File: rtl/inst_fetch_bridge_line_buf.sv
// Instruction line buffer: NUM_ENT {valid, tag, data} entries, round-robin fill, combinational hit.
// Lookup is zero-latency; writes land on the clock edge; flush clears every valid bit.
module inst_line_buf
    import inst_fetch_bridge_pkg::*;
#(
    parameter int TAG_W   = LINE_TAG_W,
    parameter int DATA_W  = INST_BUS_W,
    parameter int NUM_ENT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              lookup_en_i,
    input  logic [TAG_W-1:0]  lookup_tag_i,
`ifdef INST_BRIDGE_PREFETCH_EN
    input  logic [TAG_W-1:0]  probe_tag_i,
    output logic              probe_hit_o,
`endif
    input  logic              wr_en_i,
    input  logic [TAG_W-1:0]  wr_tag_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              hit_o,
    output logic [DATA_W-1:0] hit_data_o
);

    logic              victim_q;
    logic [NUM_ENT-1:0] hit_vec;
    logic [DATA_W-1:0] ent_data [NUM_ENT];
`ifdef INST_BRIDGE_PREFETCH_EN
    logic [NUM_ENT-1:0] probe_vec;
`endif

    for (genvar i = 0; i < NUM_ENT; i++) begin : g_ent
        logic              vld_q;
        logic [TAG_W-1:0]  tag_q;
        logic [DATA_W-1:0] dat_q;
        logic              sel;

        assign sel = wr_en_i && (victim_q == 1'(i));

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                vld_q <= 1'b0;
                tag_q <= '0;
                dat_q <= '0;
            end else if (clr_i) begin
                vld_q <= 1'b0;
            end else if (sel) begin
                vld_q <= 1'b1;
                tag_q <= wr_tag_i;
                dat_q <= wr_data_i;
            end
        end

        assign hit_vec[i]  = vld_q && (tag_q == lookup_tag_i);
        assign ent_data[i] = dat_q;
`ifdef INST_BRIDGE_PREFETCH_EN
        assign probe_vec[i] = vld_q && (tag_q == probe_tag_i);
`endif
    end

    // Single-entry builds keep the victim pinned at entry 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            victim_q <= 1'b0;
        end else if (wr_en_i && !clr_i && (NUM_ENT > 1)) begin
            victim_q <= ~victim_q;
        end
    end

    always_comb begin
        hit_data_o = '0;
        for (int i = 0; i < NUM_ENT; i++) begin
            if (hit_vec[i]) hit_data_o = hit_data_o | ent_data[i];
        end
    end

    assign hit_o = lookup_en_i && (|hit_vec);
`ifdef INST_BRIDGE_PREFETCH_EN
    assign probe_hit_o = |probe_vec;
`endif

endmodule

// File: rtl/inst_fetch_bridge.sv
// Instruction fetch bridge: line-buffer hit returns same cycle, miss stalls >=3 cycles (IDLE/REQ/WAIT);
// request held until inst_addr_ok_i, one transaction outstanding. INST_BRIDGE_PREFETCH_EN adds next-line prefetch.
module inst_fetch_bridge
    import inst_fetch_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_ce_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    output logic [DATA_W-1:0] cpu_inst_o,
    output logic              stallreq_o,
    input  logic              flush_i,
    output logic              inst_req_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    input  logic              inst_addr_ok_i,
    input  logic              inst_data_ok_i,
    input  logic [DATA_W-1:0] inst_rdata_i
);

    localparam int TAG_W = ADDR_W - 2;
`ifdef INST_BRIDGE_PREFETCH_EN
    localparam int NUM_ENT = 2;
`else
    localparam int NUM_ENT = 1;
`endif

    fetch_state_e      state_q, state_d;
    logic [TAG_W-1:0]  req_tag_q, req_tag_d;
    logic              flush_pend_q, flush_pend_d;
    logic [TAG_W-1:0]  cpu_tag;
    logic              misaligned, hit, miss, buf_wr;
    logic [DATA_W-1:0] hit_data;
`ifdef INST_BRIDGE_PREFETCH_EN
    logic              probe_hit;
`endif

    assign cpu_tag    = cpu_addr_i[ADDR_W-1:2];
    assign misaligned = (cpu_addr_i[1:0] != 2'b00);
    assign miss       = cpu_ce_i && !hit && !misaligned;

    inst_line_buf #(
        .TAG_W   (TAG_W),
        .DATA_W  (DATA_W),
        .NUM_ENT (NUM_ENT)
    ) u_line_buf (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (flush_i),
        .lookup_en_i  (cpu_ce_i),
        .lookup_tag_i (cpu_tag),
`ifdef INST_BRIDGE_PREFETCH_EN
        .probe_tag_i  (cpu_tag + TAG_W'(1)),
        .probe_hit_o  (probe_hit),
`endif
        .wr_en_i      (buf_wr),
        .wr_tag_i     (req_tag_q),
        .wr_data_i    (inst_rdata_i),
        .hit_o        (hit),
        .hit_data_o   (hit_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            req_tag_q    <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_tag_q    <= req_tag_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        req_tag_d    = req_tag_q;
        flush_pend_d = flush_pend_q;
        buf_wr       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                flush_pend_d = 1'b0;
                if (!flush_i && miss) begin
                    state_d   = ST_REQ;
                    req_tag_d = cpu_tag;
                end
`ifdef INST_BRIDGE_PREFETCH_EN
                else if (!flush_i && hit && !misaligned && !probe_hit) begin
                    state_d   = ST_REQ;
                    req_tag_d = cpu_tag + TAG_W'(1);
                end
`endif
            end
            // A flush mid-handshake is remembered so the response can be dropped later.
            ST_REQ: begin
                if (flush_i) flush_pend_d = 1'b1;
                if (inst_addr_ok_i) begin
                    state_d = (flush_i || flush_pend_q) ? ST_CANCEL : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (inst_data_ok_i) begin
                    buf_wr  = !flush_i;
                    state_d = ST_IDLE;
                end else if (flush_i) begin
                    state_d = ST_CANCEL;
                end
            end
            ST_CANCEL: begin
                if (inst_data_ok_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign inst_req_o  = (state_q == ST_REQ);
    assign inst_addr_o = {req_tag_q, 2'b00};
    assign cpu_inst_o  = (hit && !misaligned) ? hit_data : DATA_W'(NOP);
    assign stallreq_o  = rst && miss;

endmodule
